// File: rtl/riscv_defines.sv
// Shared DIFT types: violation classes, tag-check configuration and trap controller states.
package riscv_defines;

  typedef enum logic [2:0] {
    DIFT_TRAP_NONE   = 3'd0,
    DIFT_TRAP_LOAD   = 3'd1,
    DIFT_TRAP_STORE  = 3'd2,
    DIFT_TRAP_JALR   = 3'd3,
    DIFT_TRAP_BRANCH = 3'd4,
    DIFT_TRAP_EXEC   = 3'd5,
    DIFT_TRAP_RSVD6  = 3'd6,
    DIFT_TRAP_RSVD7  = 3'd7
  } dift_trap_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       chk_exec;
    logic       chk_branch;
    logic       chk_jalr;
    logic       chk_store;
    logic       chk_load;
  } dift_tccr_t;

  typedef enum logic [1:0] {
    TC_IDLE   = 2'd0,
    TC_REQ    = 2'd1,
    TC_HANDLE = 2'd2
  } dift_trapctrl_state_t;

  localparam int unsigned VIOL_CNT_W = 16;
  localparam dift_tccr_t  TCCR_ALL_OFF = '0;

endpackage

// File: rtl/dift_sat_counter.sv
// Saturating up-counter; a clear request has priority over an increment.
module dift_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;

  // count register: clear wins, otherwise increment until all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != {WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/dift_trap_ctrl.sv
// DIFT trap controller: latches the first violation, handshakes a trap request with the core,
// and applies tag-check configuration writes, deferring those made while a request is pending.
module dift_trap_ctrl
  import riscv_defines::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_i,
  input  dift_trap_t            trap_type_i,
  input  logic [31:0]           trap_pc_i,
  output logic                  trap_req_o,
  output dift_trap_t            trap_type_o,
  input  logic                  trap_ack_i,
  input  logic                  handler_done_i,
  input  logic                  tccr_we_i,
  input  dift_tccr_t            tccr_wdata_i,
  output dift_tccr_t            tccr_o,
  output logic [31:0]           epc_o,
  output logic                  overflow_o,
  output logic [VIOL_CNT_W-1:0] viol_cnt_o,
  input  logic                  clr_i,
  output logic                  busy_o
);

  dift_trapctrl_state_t state_r;
  logic                 trap_req_r;
  dift_trap_t           trap_type_r;
  logic [31:0]          epc_r;
  dift_tccr_t           tccr_r;
  dift_tccr_t           shadow_r;
  logic                 shadow_vld_r;
  logic                 overflow_r;

  // trap FSM with its latched request, cause, PC and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= TC_IDLE;
      trap_req_r   <= 1'b0;
      trap_type_r  <= DIFT_TRAP_NONE;
      epc_r        <= 32'h0000_0000;
      tccr_r       <= TCCR_ALL_OFF;
      shadow_r     <= TCCR_ALL_OFF;
      shadow_vld_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      case (state_r)
        TC_IDLE: begin
          if (trap_i) begin
            trap_type_r <= trap_type_i;
            epc_r       <= trap_pc_i;
            trap_req_r  <= 1'b1;
            state_r     <= TC_REQ;
          end
          if (tccr_we_i) begin
            tccr_r <= tccr_wdata_i;
          end
        end
        TC_REQ: begin
          // the check unit must not see a new config until the core has taken the trap
          if (tccr_we_i) begin
            shadow_r     <= tccr_wdata_i;
            shadow_vld_r <= 1'b1;
          end
          if (trap_ack_i) begin
            trap_req_r   <= 1'b0;
            state_r      <= TC_HANDLE;
            shadow_vld_r <= 1'b0;
            if (tccr_we_i) begin
              tccr_r <= tccr_wdata_i;
            end else if (shadow_vld_r) begin
              tccr_r <= shadow_r;
            end
          end
        end
        TC_HANDLE: begin
          if (handler_done_i) begin
            state_r <= TC_IDLE;
          end
          if (tccr_we_i) begin
            tccr_r <= tccr_wdata_i;
          end
        end
        default: begin
          state_r    <= TC_IDLE;
          trap_req_r <= 1'b0;
        end
      endcase

      if (clr_i) begin
        overflow_r <= 1'b0;
      end else if (trap_i && (state_r != TC_IDLE)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  dift_sat_counter #(.WIDTH(VIOL_CNT_W)) u_viol_cnt (
    .clk (clk),
    .rst (rst),
    .inc (trap_i),
    .clr (clr_i),
    .cnt (viol_cnt_o)
  );

  assign trap_req_o  = trap_req_r;
  assign trap_type_o = trap_type_r;
  assign epc_o       = epc_r;
  assign tccr_o      = tccr_r;
  assign overflow_o  = overflow_r;
  assign busy_o      = (state_r != TC_IDLE);

endmodule

// File: tb/tb_dift_trap_ctrl.sv
// Directed bench for dift_trap_ctrl: expectations queued per step, compared after each clock edge.
module tb_dift_trap_ctrl;
  import riscv_defines::*;

  logic            clk;
  logic            rst;
  logic            trap_i;
  dift_trap_t      trap_type_i;
  logic [31:0]     trap_pc_i;
  logic            trap_req_o;
  dift_trap_t      trap_type_o;
  logic            trap_ack_i;
  logic            handler_done_i;
  logic            tccr_we_i;
  dift_tccr_t      tccr_wdata_i;
  dift_tccr_t      tccr_o;
  logic [31:0]     epc_o;
  logic            overflow_o;
  logic [15:0]     viol_cnt_o;
  logic            clr_i;
  logic            busy_o;

  dift_trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .trap_i         (trap_i),
    .trap_type_i    (trap_type_i),
    .trap_pc_i      (trap_pc_i),
    .trap_req_o     (trap_req_o),
    .trap_type_o    (trap_type_o),
    .trap_ack_i     (trap_ack_i),
    .handler_done_i (handler_done_i),
    .tccr_we_i      (tccr_we_i),
    .tccr_wdata_i   (tccr_wdata_i),
    .tccr_o         (tccr_o),
    .epc_o          (epc_o),
    .overflow_o     (overflow_o),
    .viol_cnt_o     (viol_cnt_o),
    .clr_i          (clr_i),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=0x%0h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    trap_i         = 1'b0;
    trap_ack_i     = 1'b0;
    handler_done_i = 1'b0;
    tccr_we_i      = 1'b0;
    clr_i          = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    trap_type_i  = DIFT_TRAP_NONE;
    trap_pc_i    = 32'h0;
    tccr_wdata_i = dift_tccr_t'(8'h00);
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    expect_val("rst_req", 32'd0);   expect_val("rst_type", 32'd0); expect_val("rst_epc", 32'd0);
    expect_val("rst_ovf", 32'd0);   expect_val("rst_cnt", 32'd0);  expect_val("rst_tccr", 32'd0);
    expect_val("rst_busy", 32'd0);
    check(32'(trap_req_o)); check(32'(trap_type_o)); check(epc_o);
    check(32'(overflow_o)); check(32'(viol_cnt_o)); check(32'(tccr_o)); check(32'(busy_o));

    // config write in IDLE
    tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h03);
    expect_val("idle_wr_tccr", 32'h03);
    tick(); idle_inputs();
    check(32'(tccr_o));

    // idle trap together with a config write; request must not appear combinationally
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_JALR; trap_pc_i = 32'h0000_1040;
    tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h11);
    #1;
    expect_val("no_comb_req", 32'd0);
    check(32'(trap_req_o));
    expect_val("trap_req", 32'd1); expect_val("trap_type", 32'd3); expect_val("trap_epc", 32'h1040);
    expect_val("trap_cnt", 32'd1); expect_val("trap_busy", 32'd1); expect_val("trap_tccr", 32'h11);
    tick(); idle_inputs();
    check(32'(trap_req_o)); check(32'(trap_type_o)); check(epc_o);
    check(32'(viol_cnt_o)); check(32'(busy_o)); check(32'(tccr_o));

    // dropped trap in REQ
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_LOAD; trap_pc_i = 32'h0000_2000;
    expect_val("drop_epc", 32'h1040); expect_val("drop_type", 32'd3); expect_val("drop_ovf", 32'd1);
    expect_val("drop_cnt", 32'd2);    expect_val("drop_req", 32'd1);
    tick(); idle_inputs();
    check(epc_o); check(32'(trap_type_o)); check(32'(overflow_o)); check(32'(viol_cnt_o)); check(32'(trap_req_o));

    // deferred config writes in REQ, handler_done ignored in REQ
    tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h05);
    tick(); idle_inputs();
    tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h0A); handler_done_i = 1'b1;
    expect_val("defer_tccr", 32'h11); expect_val("done_in_req_req", 32'd1); expect_val("done_in_req_busy", 32'd1);
    tick(); idle_inputs();
    check(32'(tccr_o)); check(32'(trap_req_o)); check(32'(busy_o));

    // ack: request drops, shadow applied
    trap_ack_i = 1'b1;
    expect_val("ack_req", 32'd0); expect_val("ack_busy", 32'd1); expect_val("ack_tccr", 32'h0A);
    tick(); idle_inputs();
    check(32'(trap_req_o)); check(32'(busy_o)); check(32'(tccr_o));

    // ack in HANDLE ignored, direct config write in HANDLE
    trap_ack_i = 1'b1; tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h0C);
    expect_val("handle_busy", 32'd1); expect_val("handle_tccr", 32'h0C);
    tick(); idle_inputs();
    check(32'(busy_o)); check(32'(tccr_o));

    // handler return
    handler_done_i = 1'b1;
    expect_val("done_busy", 32'd0); expect_val("done_req", 32'd0);
    tick(); idle_inputs();
    check(32'(busy_o)); check(32'(trap_req_o));

    // clear counters
    clr_i = 1'b1;
    expect_val("clr_ovf", 32'd0); expect_val("clr_cnt", 32'd0);
    tick(); idle_inputs();
    check(32'(overflow_o)); check(32'(viol_cnt_o));

    // trap + handler_done in the same HANDLE cycle
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_EXEC; trap_pc_i = 32'h0000_3000;
    tick(); idle_inputs();
    trap_ack_i = 1'b1;
    tick(); idle_inputs();
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_STORE; trap_pc_i = 32'h0000_3333; handler_done_i = 1'b1;
    expect_val("race_busy", 32'd0); expect_val("race_ovf", 32'd1); expect_val("race_cnt", 32'd2);
    expect_val("race_epc", 32'h3000); expect_val("race_type", 32'd5);
    tick(); idle_inputs();
    check(32'(busy_o)); check(32'(overflow_o)); check(32'(viol_cnt_o)); check(epc_o); check(32'(trap_type_o));

    // saturation
    clr_i = 1'b1;
    tick(); idle_inputs();
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_BRANCH; trap_pc_i = 32'h0000_5000;
    for (int i = 0; i < 65540; i++) tick();
    trap_i = 1'b0;
    expect_val("sat_cnt", 32'h0000_FFFF); expect_val("sat_ovf", 32'd1);
    check(32'(viol_cnt_o)); check(32'(overflow_o));

    // clear beats a same-cycle increment
    trap_i = 1'b1; clr_i = 1'b1;
    expect_val("clr_win_cnt", 32'd0); expect_val("clr_win_ovf", 32'd0);
    tick(); idle_inputs();
    check(32'(viol_cnt_o)); check(32'(overflow_o));

    // shadow write in REQ, then asynchronous reset mid-cycle
    tccr_we_i = 1'b1; tccr_wdata_i = dift_tccr_t'(8'h07);
    expect_val("pre_rst_req", 32'd1); expect_val("pre_rst_tccr", 32'h0C);
    tick(); idle_inputs();
    check(32'(trap_req_o)); check(32'(tccr_o));
    #2 rst = 1'b1;
    #1;
    expect_val("async_rst_req", 32'd0); expect_val("async_rst_tccr", 32'd0); expect_val("async_rst_busy", 32'd0);
    check(32'(trap_req_o)); check(32'(tccr_o)); check(32'(busy_o));
    tick();
    rst = 1'b0;

    // shadow must not survive the reset
    trap_i = 1'b1; trap_type_i = DIFT_TRAP_STORE; trap_pc_i = 32'h0000_4000;
    tick(); idle_inputs();
    trap_ack_i = 1'b1;
    expect_val("post_rst_tccr", 32'd0); expect_val("post_rst_epc", 32'h4000); expect_val("post_rst_busy", 32'd1);
    tick(); idle_inputs();
    check(32'(tccr_o)); check(epc_o); check(32'(busy_o));

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dift_trap_ctrl.md
DIFT_TRAP_CTRL -- requirements
Module: dift_trap_ctrl

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset; all other ports follow in the order listed.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 trap_i  input  1  one-cycle violation tick from the tag check unit.
REQ-005 trap_type_i  input  dift_trap_t (3)  violation class, valid with trap_i.
REQ-006 trap_pc_i  input  32  PC of the violating instruction, valid with trap_i.
REQ-007 trap_req_o  output  1  DIFT trap request to the core controller.
REQ-008 trap_type_o  output  dift_trap_t (3)  latched violation class.
REQ-009 trap_ack_i  input  1  controller has entered the DIFT handler.
REQ-010 handler_done_i  input  1  one-cycle pulse: DIFT handler returned.
REQ-011 tccr_we_i  input  1  write strobe for the check configuration.
REQ-012 tccr_wdata_i  input  dift_tccr_t  new check configuration.
REQ-013 tccr_o  output  dift_tccr_t  active configuration driven to the tag check unit.
REQ-014 epc_o  output  32  latched trap PC.
REQ-015 overflow_o  output  1  sticky: violation dropped while a trap was outstanding.
REQ-016 viol_cnt_o  output  16  saturating count of all trap_i ticks.
REQ-017 clr_i  input  1  clears overflow_o and viol_cnt_o.
REQ-018 busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, HANDLE.
REQ-020 IDLE, trap_i=1: latch trap_type_i to trap_type_o and trap_pc_i to epc_o; go to REQ. trap_req_o is high from the next cycle (registered; latency 1).
REQ-021 REQ: trap_req_o, trap_type_o and epc_o held stable until trap_ack_i=1; on ack go to HANDLE; trap_req_o low from the next cycle.
REQ-022 HANDLE: handler_done_i=1 returns to IDLE on the next edge.
REQ-023 trap_ack_i in IDLE/HANDLE and handler_done_i in IDLE/REQ SHALL be ignored.
REQ-024 trap_i in REQ or HANDLE SHALL NOT update trap_type_o/epc_o and SHALL set overflow_o.
REQ-025 trap_i and handler_done_i in the same HANDLE cycle: go to IDLE; the tick is treated as dropped (overflow_o set).
REQ-026 viol_cnt_o SHALL increment by 1 on every trap_i in any state and saturate at 0xFFFF.
REQ-027 clr_i SHALL win over a same-cycle increment or overflow set; viol_cnt_o=0 and overflow_o=0 next cycle.
REQ-028 tccr_we_i in IDLE or HANDLE: tccr_o takes tccr_wdata_i on the next edge.
REQ-029 tccr_we_i in REQ: the value goes to a pending shadow; a later write in REQ overwrites it; the shadow is applied to tccr_o on the REQ->HANDLE transition.
REQ-030 A write in the same cycle as trap_i in IDLE SHALL take effect (both the latch and the config update occur).
REQ-031 busy_o SHALL be combinational from the state register.

Reset
REQ-032 On rst: state=IDLE, trap_req_o=0, trap_type_o=0, epc_o=0, overflow_o=0, viol_cnt_o=0, tccr_o=all checks OFF ('0), pending shadow cleared.
REQ-033 Reset asserted in any state SHALL abort the outstanding request immediately (asynchronously) without waiting for ack.

Structure
REQ-034 dift_trap_t, dift_tccr_t and the new enum dift_trapctrl_state_t SHALL live in riscv_defines.
REQ-035 The saturating counter SHALL be a sub-module dift_sat_counter (parameter WIDTH=16; inc, clr, async active-high reset).
REQ-036 No combinational path SHALL exist from trap_i to trap_req_o.

Verification
REQ-037 Idle trap: trap_i, type=3 (JALR), pc=0x0000_1040 -> next cycle trap_req_o=1, trap_type_o=3, epc_o=0x1040, viol_cnt_o=1.
REQ-038 Ack/return: ack 4 cycles after request -> trap_req_o=0 next cycle, busy_o=1; handler_done_i -> IDLE, busy_o=0.
REQ-039 Drop: second trap_i (type=1, pc=0x2000) in REQ -> epc_o stays 0x1040, overflow_o=1, viol_cnt_o=2.
REQ-040 Deferred config: tccr writes 0x05 then 0x0A during REQ -> tccr_o unchanged until ack, then 0x0A.
REQ-041 Saturation/clear: 65 540 ticks -> viol_cnt_o=0xFFFF; clr_i with trap_i same cycle -> viol_cnt_o=0.
REQ-042 Reset in REQ: rst pulse -> trap_req_o=0 and tccr_o=0 before the next clock edge.
